irq_gateway: RTL

- Interrupt controller sitting directly upstream of the CPU core's `external_int` input.
- Synchronises up to NUM_SRC asynchronous device interrupt lines and latches them as pending.
- Applies per-source enable and edge/level mode, picks the highest-priority eligible source, and drives a single `ext_int` request to the core.
- The core services the request through a claim/complete handshake on a small word-addressed register port driven from its data-memory bus.

---
 rtl/irq_gateway.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/irq_gateway.sv
// Interrupt gateway: synchronises device lines, latches pending, arbitrates by
// lowest index and runs a claim/complete handshake with the core.
module irq_gateway #(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               bus_we,
    input  logic               bus_re,
    input  logic [3:0]         bus_addr,
    input  logic [31:0]        bus_wdata,
    output logic [31:0]        bus_rdata,
    output logic               ext_int
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_MODE    = 2'd2;
    localparam logic [1:0] REG_CLAIM   = 2'd3;
    localparam int         PAD         = 32 - NUM_SRC;

    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_reg;
    logic [NUM_SRC-1:0] prev_reg;
    logic [NUM_SRC-1:0] pending_reg, pending_next;
    logic [NUM_SRC-1:0] enable_reg;
    logic [NUM_SRC-1:0] mode_reg;
    logic [4:0]         claimed_id_reg;
    logic [31:0]        rdata_reg;
    logic               ext_int_reg;
    state_t             state_reg, state_next;

    logic [NUM_SRC-1:0] sync_lvl;
    logic [NUM_SRC-1:0] edge_set;
    logic [NUM_SRC-1:0] edge_clr;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] win_mask;
    logic [4:0]         win_id;
    logic [1:0]         reg_sel;
    logic               claim_rd;
    logic               complete_wr;
    logic               grant;
    logic               release_ok;
    logic [31:0]        rd_val;
    logic               unused_bits;

    assign reg_sel     = bus_addr[3:2];
    assign claim_rd    = bus_re && (reg_sel == REG_CLAIM);
    assign complete_wr = bus_we && (reg_sel == REG_CLAIM);
    assign sync_lvl    = sync_reg[SYNC_STAGES-1];
    assign edge_set    = sync_lvl & ~prev_reg;
    assign eligible    = pending_reg & enable_reg;
    assign unused_bits = ^{bus_addr[1:0], bus_wdata};

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        win_id   = 5'd0;
        win_mask = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id      = 5'(i + 1);
                win_mask    = '0;
                win_mask[i] = 1'b1;
            end
        end
    end

    // FSM output process: handshake qualifiers for the current cycle.
    always_comb begin
        grant      = 1'b0;
        release_ok = 1'b0;
        case (state_reg)
            IDLE: grant      = claim_rd && (|eligible);
            BUSY: release_ok = complete_wr && (bus_wdata[4:0] == claimed_id_reg);
            default: ;
        endcase
    end

    // FSM next-state process.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (grant)      state_next = BUSY;
            BUSY: if (release_ok) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        edge_clr = grant ? win_mask : '0;
        if (bus_we && (reg_sel == REG_PENDING)) begin
            edge_clr = edge_clr | bus_wdata[NUM_SRC-1:0];
        end
    end

    // Per-source pending update; a set always overrides a same-cycle clear.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_pend
            assign pending_next[gi] = mode_reg[gi]
                ? (edge_set[gi] | (pending_reg[gi] & ~edge_clr[gi]))
                : sync_lvl[gi];
        end
    endgenerate

    always_comb begin
        rd_val = 32'd0;
        case (reg_sel)
            REG_PENDING: rd_val = {{PAD{1'b0}}, pending_reg};
            REG_ENABLE:  rd_val = {{PAD{1'b0}}, enable_reg};
            REG_MODE:    rd_val = {{PAD{1'b0}}, mode_reg};
            REG_CLAIM:   rd_val = grant ? {27'd0, win_id} : 32'd0;
            default:     rd_val = 32'd0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_reg       <= '0;
            prev_reg       <= '0;
            pending_reg    <= '0;
            enable_reg     <= '0;
            mode_reg       <= '0;
            claimed_id_reg <= 5'd0;
            rdata_reg      <= 32'd0;
            ext_int_reg    <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[SYNC_STAGES-2:0], irq_src};
            prev_reg    <= sync_lvl;
            pending_reg <= pending_next;
            if (bus_we && (reg_sel == REG_ENABLE)) begin
                enable_reg <= bus_wdata[NUM_SRC-1:0];
            end
            if (bus_we && (reg_sel == REG_MODE)) begin
                mode_reg <= bus_wdata[NUM_SRC-1:0];
            end
            if (grant) begin
                claimed_id_reg <= win_id;
            end else if (release_ok) begin
                claimed_id_reg <= 5'd0;
            end
            if (bus_re) begin
                rdata_reg <= rd_val;
            end
            ext_int_reg <= (state_reg == IDLE) && (|eligible);
        end
    end

    assign bus_rdata = rdata_reg;
    assign ext_int   = ext_int_reg;

endmodule
